// File: rtl/ar_tx_pkg.sv
// ar_tx_pkg: shared state type and word field widths for the ARINC word scheduler
package ar_tx_pkg;
    localparam int ADR_W  = 8;
    localparam int DAT_W  = 23;
    localparam int NVEL_W = 2;
    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_e;
endpackage

// File: rtl/ar_tx_sched_rr_pick.sv
// rr_pick: combinational round-robin picker searching upward from last+1 with wrap
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            vld
);
    logic [IW-1:0] j;
    // walk candidates farthest-first so the nearest requester after last wins
    always_comb begin
        idx = '0;
        vld = 1'b0;
        j   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = IW'((32'(last) + 32'(k)) % NREQ);
            if (req[j]) begin
                idx = j;
                vld = 1'b1;
            end
        end
        gnt = vld ? (NREQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/ar_tx_sched.sv
// ar_tx_sched: round-robin scheduler feeding word requests to one ARINC transmitter
module ar_tx_sched
    import ar_tx_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int GAP_BITS = 4,
    parameter int BUSY_TO  = 32,
    parameter int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [8*NREQ-1:0]  req_adr,
    input  logic [23*NREQ-1:0] req_dat,
    input  logic [NVEL_W-1:0]  Nvel_cfg,
    input  logic               ce_tact,
    input  logic               en_tx,
    output logic               st,
    output logic [ADR_W-1:0]   ADR,
    output logic [DAT_W-1:0]   DAT,
    output logic [NVEL_W-1:0]  Nvel,
    output logic [NREQ-1:0]    ack,
    output logic               busy,
    output logic [IW-1:0]      cur_id,
    output logic               err
);
    localparam int TW = (BUSY_TO > 2) ? $clog2(BUSY_TO) : 1;
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    state_e              state_q, state_d;
    logic                st_q, st_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [ADR_W-1:0]    adr_q, adr_d;
    logic [DAT_W-1:0]    dat_q, dat_d;
    logic [NVEL_W-1:0]   nvel_q, nvel_d;
    logic [IW-1:0]       cur_id_q, cur_id_d;
    logic                err_q, err_d;
    logic [TW-1:0]       to_cnt_q, to_cnt_d;
    logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
    logic [NREQ-1:0]     gnt;
    logic [IW-1:0]       gidx;
    logic                gvld;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req  (req),
        .last (cur_id_q),
        .gnt  (gnt),
        .idx  (gidx),
        .vld  (gvld)
    );

    // sequencing: grant in IDLE, pulse st, wait for the transmitter, then enforce the gap
    always_comb begin
        state_d  = state_q;
        st_d     = 1'b0;
        ack_d    = '0;
        adr_d    = adr_q;
        dat_d    = dat_q;
        nvel_d   = nvel_q;
        cur_id_d = cur_id_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (gvld) begin
                state_d  = START;
                st_d     = 1'b1;
                ack_d    = gnt;
                adr_d    = req_adr[ADR_W*gidx +: ADR_W];
                dat_d    = req_dat[DAT_W*gidx +: DAT_W];
                nvel_d   = Nvel_cfg;
                cur_id_d = gidx;
            end
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (en_tx) state_d = WAIT_DONE;
                       else if (to_cnt_q == TW'(BUSY_TO - 2)) begin
                           err_d   = 1'b1;
                           state_d = IDLE;
                       end
            WAIT_DONE: if (!en_tx) state_d = GAP;
            GAP:       if (ce_tact && gap_cnt_q == GW'(GAP_BITS - 1)) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        to_cnt_d  = (state_q == WAIT_BUSY && state_d == WAIT_BUSY) ? to_cnt_q + TW'(1) : '0;
        gap_cnt_d = (state_q == GAP && state_d == GAP) ? gap_cnt_q + GW'(ce_tact) : '0;
    end

    // register all state and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            st_q      <= 1'b0;
            ack_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            nvel_q    <= '0;
            cur_id_q  <= IW'(NREQ - 1);
            err_q     <= 1'b0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            st_q      <= st_d;
            ack_q     <= ack_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            nvel_q    <= nvel_d;
            cur_id_q  <= cur_id_d;
            err_q     <= err_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign st     = st_q;
    assign ack    = ack_q;
    assign ADR    = adr_q;
    assign DAT    = dat_q;
    assign Nvel   = nvel_q;
    assign cur_id = cur_id_q;
    assign err    = err_q;
    assign busy   = (state_q != IDLE);
endmodule

// File: tb/tb_ar_tx_sched.sv
// tb_ar_tx_sched: directed bench with a behavioural scheduler model checked every cycle
module tb_ar_tx_sched;
    localparam int NREQ = 4, GAP_BITS = 4, BUSY_TO = 32;
    localparam int P_IDLE = 0, P_START = 1, P_WB = 2, P_WD = 3, P_GAP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req = '0;
    logic [31:0] req_adr = {8'h44, 8'h33, 8'h22, 8'hFF};
    logic [91:0] req_dat = {23'h444444, 23'h333333, 23'h222222, 23'h111111};
    logic [1:0] nvel_cfg = '0;
    logic ce_tact = 1'b0, en_tx = 1'b0;
    logic st, busy, err;
    logic [7:0] ADR;
    logic [22:0] DAT;
    logic [1:0] Nvel, cur_id;
    logic [3:0] ack;

    ar_tx_sched #(.NREQ(NREQ), .GAP_BITS(GAP_BITS), .BUSY_TO(BUSY_TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_adr(req_adr), .req_dat(req_dat),
        .Nvel_cfg(nvel_cfg), .ce_tact(ce_tact), .en_tx(en_tx), .st(st), .ADR(ADR),
        .DAT(DAT), .Nvel(Nvel), .ack(ack), .busy(busy), .cur_id(cur_id), .err(err)
    );

    always #5 clk = ~clk;

    // behavioural model: phase, cycles since grant / gap pulses, and the presented word
    int m_ph = P_IDLE, m_tmr = 0, m_cur = NREQ - 1;
    logic m_st = 1'b0, m_err = 1'b0;
    logic [3:0] m_ack = '0;
    logic [7:0] m_adr = '0;
    logic [22:0] m_dat = '0;
    logic [1:0] m_nvel = '0, m_g;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = P_IDLE; m_tmr = 0; m_cur = NREQ - 1; m_st = 1'b0; m_err = 1'b0;
            m_ack = '0; m_adr = '0; m_dat = '0; m_nvel = '0;
        end else begin
            m_st = 1'b0;
            m_ack = '0;
            case (m_ph)
                P_IDLE: for (int k = 1; k <= NREQ; k++) begin
                    m_g = 2'((m_cur + k) % NREQ);
                    if (m_ph == P_IDLE && req[m_g]) begin
                        m_ph = P_START; m_tmr = 0; m_st = 1'b1; m_ack[m_g] = 1'b1;
                        m_adr = req_adr[8*m_g +: 8]; m_dat = req_dat[23*m_g +: 23];
                        m_nvel = nvel_cfg; m_cur = int'(m_g);
                    end
                end
                P_START: begin m_tmr++; m_ph = P_WB; end
                P_WB: begin
                    m_tmr++;
                    if (en_tx) m_ph = P_WD;
                    else if (m_tmr == BUSY_TO) begin m_err = 1'b1; m_ph = P_IDLE; end
                end
                P_WD: if (!en_tx) begin m_ph = P_GAP; m_tmr = 0; end
                default: begin
                    if (ce_tact) m_tmr++;
                    if (m_tmr == GAP_BITS) m_ph = P_IDLE;
                end
            endcase
        end
    end

    int pass_cnt = 0, total_cnt = 0, cyc = 0, st_cyc = 0, tx_t = -1, gap_cnt = 0;
    bit tx_auto = 1'b1, seen_done = 1'b0;
    logic [3:0] drop_mask = 4'b1111;
    int glog[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // one cycle: compare against the model, observe, then drive transmitter and requesters
    task automatic step();
        @(negedge clk);
        cyc++;
        chk("model", 64'({st, ack, ADR, DAT, Nvel, busy, cur_id, err}),
            64'({m_st, m_ack, m_adr, m_dat, m_nvel, m_ph != P_IDLE, 2'(m_cur), m_err}));
        for (int i = 0; i < NREQ; i++) if (ack[i]) glog.push_back(i);
        if (st && seen_done) chk("gap_pulses", 64'(gap_cnt >= GAP_BITS), 64'(1));
        if (st) st_cyc = cyc;
        if (tx_auto) begin
            if (st) tx_t = 0;
            else if (tx_t >= 0) tx_t++;
            en_tx = (tx_t >= 2 && tx_t < 6);
            if (tx_t == 6) begin gap_cnt = 0; seen_done = 1'b1; tx_t = -1; end
        end
        ce_tact = (cyc % 3 == 0);
        if (ce_tact && !en_tx) gap_cnt++;
        req = req & ~(ack & drop_mask);
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    task automatic wait_st(input int lim);
        int n = 0;
        do begin step(); n++; end while (!st && n < lim);
        chk("wait_st", 64'(st), 64'(1));
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        do begin step(); n++; end while (busy && n < lim);
        chk("wait_idle", 64'(busy), 64'(0));
    endtask

    task automatic wait_grants(input int cnt, input int lim);
        int n = 0;
        while (glog.size() < cnt && n < lim) begin step(); n++; end
        chk("grant_count", 64'(glog.size()), 64'(cnt));
    endtask

    initial begin
        int exp4[4] = '{0, 1, 2, 3};
        int exp6[6] = '{0, 2, 0, 2, 0, 2};
        int to_start;
        do_reset();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cur", 64'(cur_id), 64'(3));
        chk("rst_adr", 64'(ADR), 64'(0));

        // single word
        nvel_cfg = 2'd1; req = 4'b0001;
        step();
        chk("w1_st", 64'(st), 64'(1));
        chk("w1_ack", 64'(ack), 64'(4'b0001));
        chk("w1_adr", 64'(ADR), 64'(8'hFF));
        chk("w1_dat", 64'(DAT), 64'(23'h111111));
        chk("w1_nvel", 64'(Nvel), 64'(1));
        wait_idle(200);

        // all four at once after reset
        do_reset();
        glog.delete();
        req = 4'b1111;
        wait_grants(4, 400);
        for (int i = 0; i < 4; i++) chk("order4", 64'(glog.size() > i ? glog[i] : -1), 64'(exp4[i]));
        wait_idle(200);

        // fairness with two held requesters
        do_reset();
        glog.delete();
        drop_mask = 4'b1010; req = 4'b0101;
        wait_grants(6, 600);
        req = 4'b0000; drop_mask = 4'b1111;
        for (int i = 0; i < 6; i++) chk("order6", 64'(glog.size() > i ? glog[i] : -1), 64'(exp6[i]));
        wait_idle(200);

        // busy timeout, then a later request is still served
        tx_auto = 1'b0; en_tx = 1'b0; req = 4'b0010;
        wait_st(20);
        to_start = st_cyc;
        for (int n = 0; n < 100 && !err; n++) step();
        chk("to_latency", 64'(cyc - to_start), 64'(BUSY_TO));
        chk("to_idle", 64'(busy), 64'(0));
        tx_auto = 1'b1; req = 4'b0100;
        wait_st(20);
        chk("to_next_ack", 64'(ack), 64'(4'b0100));
        chk("err_sticky", 64'(err), 64'(1));
        wait_idle(200);

        // reset mid-word while the transmitter is busy
        tx_auto = 1'b0; req = 4'b0001;
        wait_st(20);
        en_tx = 1'b1;
        step(); step(); step();
        chk("mid_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        step();
        chk("mr_busy", 64'(busy), 64'(0));
        chk("mr_adr", 64'(ADR), 64'(0));
        chk("mr_dat", 64'(DAT), 64'(0));
        chk("mr_err", 64'(err), 64'(0));
        chk("mr_cur", 64'(cur_id), 64'(3));
        rst = 1'b0; en_tx = 1'b0; tx_auto = 1'b1; req = 4'b1000;
        step();
        chk("mr_ack", 64'(ack), 64'(4'b1000));
        wait_idle(200);

        // rate config is frozen between grants
        nvel_cfg = 2'd1; req = 4'b0001;
        wait_st(20);
        for (int n = 0; n < 20 && !en_tx; n++) step();
        step();
        nvel_cfg = 2'd2;
        step();
        chk("cfg_hold", 64'(Nvel), 64'(1));
        wait_idle(200);
        chk("cfg_hold_idle", 64'(Nvel), 64'(1));
        req = 4'b0010;
        wait_st(20);
        chk("cfg_new", 64'(Nvel), 64'(2));
        wait_idle(200);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/ar_tx_sched.md
AR_TX_SCHED -- requirements
Module: ar_tx_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of word requesters sharing one ARINC transmitter.
REQ-002 SHALL have parameter GAP_BITS, default 4: minimum inter-word gap, counted in ce_tact pulses.
REQ-003 SHALL have parameter BUSY_TO, default 32: clk cycles allowed between st and en_tx rising.
REQ-004 SHALL have port clk  in  1: single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-006 SHALL have port req  in  NREQ: per-requester word-pending level.
REQ-007 SHALL have port req_adr  in  8*NREQ: label of requester i at bits [8i+7:8i].
REQ-008 SHALL have port req_dat  in  23*NREQ: data field of requester i at bits [23i+22:23i].
REQ-009 SHALL have port Nvel_cfg  in  2: rate selection for the next word.
REQ-010 SHALL have port ce_tact  in  1: bit-rate strobe from the transmitter.
REQ-011 SHALL have port en_tx  in  1: transmitter busy; high while a word is on the line.
REQ-012 SHALL have port st  out  1: one-cycle start pulse to the transmitter.
REQ-013 SHALL have ports ADR  out  8, DAT  out  23, Nvel  out  2: word and rate presented to the transmitter.
REQ-014 SHALL have port ack  out  NREQ: one-hot, one-cycle pulse when a requester's word is latched.
REQ-015 SHALL have ports busy  out  1 (state not IDLE), cur_id  out  2 (last granted index), err  out  1 (sticky timeout flag).

Function
REQ-016 SHALL implement states IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
REQ-017 IDLE with any req bit high SHALL, on the next edge: grant one index by round-robin, load ADR/DAT from that slot, load Nvel from Nvel_cfg, set cur_id, assert ack[i] and st, and go to START.
REQ-018 Round-robin SHALL search from cur_id+1 upward, wrapping modulo NREQ; after reset the search SHALL start at index 0.
REQ-019 START SHALL last exactly one cycle (st high only there); it SHALL then go to WAIT_BUSY with st=0 and ack=0.
REQ-020 WAIT_BUSY SHALL go to WAIT_DONE when en_tx=1; after BUSY_TO cycles without en_tx it SHALL set err and go to IDLE.
REQ-021 WAIT_DONE SHALL go to GAP on the first cycle en_tx=0.
REQ-022 GAP SHALL count ce_tact pulses; after the GAP_BITS-th pulse it SHALL go to IDLE.
REQ-023 Latency from req sampled high in IDLE to st/ack high SHALL be exactly one clk cycle.
REQ-024 ADR, DAT and Nvel SHALL be held constant from grant until the next grant; Nvel_cfg changes outside IDLE SHALL be ignored.
REQ-025 A requester SHALL keep req high until its ack; req still high in the cycle after ack SHALL count as a new word.
REQ-026 req changes outside IDLE SHALL not affect the current word; pending requests SHALL be arbitrated at the next IDLE.
REQ-027 err SHALL stay set until rst; err SHALL not block further grants.
REQ-028 The BUSY_TO and gap counters SHALL be sized by $clog2 and SHALL clear on every state entry.

Reset
REQ-029 rst SHALL force state=IDLE, st=0, ack=0, ADR=0, DAT=0, Nvel=0, cur_id=NREQ-1, err=0, counters=0.
REQ-030 rst asserted mid-word SHALL abort the sequence; no st SHALL be issued until rst is low and a req is sampled.

Structure
REQ-031 Package ar_tx_pkg SHALL hold the state enum, ADR_W=8, DAT_W=23, NVEL_W=2.
REQ-032 The round-robin picker SHALL be a combinational sub-module rr_pick (inputs req and last index; outputs a one-hot grant, an index and a valid flag).

Verification
REQ-033 Single word: req[0]=1, adr0=8'hFF, dat0=23'h111111, Nvel_cfg=1 -> next cycle st=1, ack=4'b0001, ADR=8'hFF, DAT=23'h111111, Nvel=1.
REQ-034 Simultaneous req=4'b1111 after reset, each dropped on its ack -> grant order 0,1,2,3; each later st at least GAP_BITS ce_tact pulses after en_tx falls.
REQ-035 Fairness: req[0] and req[2] held high for six words -> grant sequence 0,2,0,2,0,2.
REQ-036 Timeout: req[1]=1 with en_tx tied 0 -> err=1 exactly BUSY_TO cycles after st, state IDLE; req[2] afterwards is still granted.
REQ-037 Reset mid-word: rst in WAIT_DONE with en_tx=1 -> next cycle busy=0, ADR=0, DAT=0, err=0, cur_id=NREQ-1; req[3]=1 then gives ack=4'b1000.
REQ-038 Config hold: Nvel_cfg changes 1 to 2 during WAIT_DONE -> Nvel stays 1 until the next grant, then becomes 2.
